// File: rtl/nx_instr_store_mc_pkg.sv
// Shared types and helpers for the multi-core instruction store.
package nx_instr_store_mc_pkg;

  // Outcome of the load port in a given cycle.
  typedef enum logic [2:0] {
    LD_IDLE,
    LD_WRITE,
    LD_BAD_CORE,
    LD_FULL,
    LD_CLEARED
  } ld_op_e;

  // Index width for n items, never below one bit.
  function automatic int min1_clog2(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/nx_instr_store_mc_rr_arbiter.sv
// Round-robin arbiter with one-hot combinational grant; pointer rests on the last grantee.
module nx_instr_store_mc_rr_arbiter
  import nx_instr_store_mc_pkg::*;
#(
  parameter int N = 2,
  localparam int PTR_W = min1_clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         en,
  output logic [N-1:0] grant
);

  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] gidx;

  // Search starts just after the last grantee and wraps, so ptr itself is checked last.
  always_comb begin
    grant = '0;
    gidx  = ptr;
    for (int i = 1; i <= N; i++) begin
      if (en && (grant == '0) && req[(int'(ptr) + i) % N]) begin
        grant[(int'(ptr) + i) % N] = 1'b1;
        gidx = PTR_W'((int'(ptr) + i) % N);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= PTR_W'(N - 1);
    end else if (|grant) begin
      ptr <= gidx;
    end
  end

endmodule

// File: rtl/nx_instr_store_mc.sv
// Instruction store shared by CORES cores: append-only loads per core region,
// round-robin fetch ports with stall, per-core populated counts and sticky flags.
module nx_instr_store_mc
  import nx_instr_store_mc_pkg::*;
#(
  parameter int INSTR_WIDTH = 15,
  parameter int MAX_INSTRS  = 512,
  parameter int CORES       = 2,
  localparam int ADDR_W = $clog2(MAX_INSTRS),
  localparam int CORE_W = min1_clog2(CORES),
  localparam int CNT_W  = ADDR_W + 1
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         clear_i,
  input  logic [CORE_W-1:0]            store_core_i,
  input  logic [INSTR_WIDTH-1:0]       store_data_i,
  input  logic                         store_valid_i,
  output logic [CORES*CNT_W-1:0]       populated_o,
  output logic [CORES-1:0]             overflow_o,
  output logic                         bad_core_o,
  input  logic [CORES*ADDR_W-1:0]      fetch_addr_i,
  input  logic [CORES-1:0]             fetch_rd_i,
  output logic [CORES*INSTR_WIDTH-1:0] fetch_data_o,
  output logic [CORES-1:0]             fetch_valid_o,
  output logic [CORES-1:0]             fetch_stall_o
);

  localparam int PHYS_W = CORE_W + ADDR_W;
  localparam int DEPTH  = CORES * MAX_INSTRS;

  typedef logic [CNT_W-1:0]  cnt_t;
  typedef logic [PHYS_W-1:0] phys_addr_t;

  logic [INSTR_WIDTH-1:0] ram [DEPTH];
  cnt_t                   populated [CORES];
  logic [CORES-1:0]       overflow;
  logic                   bad_core;

  ld_op_e                 ld_op_p0;
  cnt_t                   ld_cnt_p0;
  logic                   ld_bad_p0;
  logic [CORES-1:0]       grant_p0;
  phys_addr_t             rd_phys_p0;
  logic                   rd_oob_p0;
  logic [INSTR_WIDTH-1:0] rd_word_p0;

  logic [INSTR_WIDTH-1:0] rsp_data_p1 [CORES];
  logic [CORES-1:0]       rsp_vld_p1;
  logic [CORES-1:0]       rsp_oob_p1;

  // ---- stage p0: load decode, arbitration, RAM access ----
  always_comb begin
    ld_op_p0  = LD_IDLE;
    ld_cnt_p0 = '0;
    ld_bad_p0 = {1'b0, store_core_i} >= (CORE_W + 1)'(CORES);
    if (!ld_bad_p0) begin
      ld_cnt_p0 = populated[store_core_i];
    end
    if (store_valid_i) begin
      if (clear_i) begin
        ld_op_p0 = LD_CLEARED;
      end else if (ld_bad_p0) begin
        ld_op_p0 = LD_BAD_CORE;
      end else if (ld_cnt_p0 == cnt_t'(MAX_INSTRS)) begin
        ld_op_p0 = LD_FULL;
      end else begin
        ld_op_p0 = LD_WRITE;
      end
    end
  end

  // Any load, even a dropped one, owns the single RAM port for the cycle.
  nx_instr_store_mc_rr_arbiter #(
    .N(CORES)
  ) u_arb (
    .clk   (clk_i),
    .rst_n (rst_i),
    .req   (fetch_rd_i),
    .en    (!store_valid_i),
    .grant (grant_p0)
  );

  assign fetch_stall_o = fetch_rd_i & ~grant_p0;

  // The range bound is the registered count, i.e. the pre-clear value in a clear cycle.
  always_comb begin
    rd_phys_p0 = '0;
    rd_oob_p0  = 1'b0;
    for (int c = 0; c < CORES; c++) begin
      if (grant_p0[c]) begin
        rd_phys_p0 = {CORE_W'(c), fetch_addr_i[c*ADDR_W +: ADDR_W]};
        rd_oob_p0  = {1'b0, fetch_addr_i[c*ADDR_W +: ADDR_W]} >= populated[c];
      end
    end
  end

  assign rd_word_p0 = ram[rd_phys_p0];

  always_ff @(posedge clk_i) begin
    if (ld_op_p0 == LD_WRITE) begin
      ram[{store_core_i, ld_cnt_p0[ADDR_W-1:0]}] <= store_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int c = 0; c < CORES; c++) begin
        populated[c] <= '0;
      end
      overflow <= '0;
      bad_core <= 1'b0;
    end else if (clear_i) begin
      for (int c = 0; c < CORES; c++) begin
        populated[c] <= '0;
      end
      overflow <= '0;
    end else begin
      unique case (ld_op_p0)
        LD_WRITE:    populated[store_core_i] <= ld_cnt_p0 + cnt_t'(1);
        LD_BAD_CORE: bad_core <= 1'b1;
        LD_FULL:     overflow[store_core_i] <= 1'b1;
        default:     ;
      endcase
    end
  end

  // ---- stage p1: per-core response slots ----
  // Reset sets the out-of-range bit, which forces the unreset data slot to read as zero.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rsp_vld_p1 <= '0;
      rsp_oob_p1 <= '1;
    end else begin
      rsp_vld_p1 <= grant_p0;
      for (int c = 0; c < CORES; c++) begin
        if (grant_p0[c]) begin
          rsp_oob_p1[c] <= rd_oob_p0;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    for (int c = 0; c < CORES; c++) begin
      if (grant_p0[c]) begin
        rsp_data_p1[c] <= rd_word_p0;
      end
    end
  end

  always_comb begin
    fetch_data_o = '0;
    populated_o  = '0;
    for (int c = 0; c < CORES; c++) begin
      fetch_data_o[c*INSTR_WIDTH +: INSTR_WIDTH] = rsp_oob_p1[c] ? '0 : rsp_data_p1[c];
      populated_o[c*CNT_W +: CNT_W]              = populated[c];
    end
  end

  assign fetch_valid_o = rsp_vld_p1;
  assign overflow_o    = overflow;
  assign bad_core_o    = bad_core;

endmodule

// File: tb/tb_nx_instr_store_mc.sv
// Bench for nx_instr_store_mc with CORES=3, MAX_INSTRS=8: reference model plus response scoreboard.
module tb_nx_instr_store_mc;

  localparam int IW   = 15;
  localparam int MI   = 8;
  localparam int NC   = 3;
  localparam int AW   = 3;
  localparam int CW   = 2;
  localparam int CNTW = 4;

  logic              clk = 1'b0;
  logic              rst_i;
  logic              clear_i;
  logic [CW-1:0]     store_core_i;
  logic [IW-1:0]     store_data_i;
  logic              store_valid_i;
  logic [NC*CNTW-1:0] populated_o;
  logic [NC-1:0]     overflow_o;
  logic              bad_core_o;
  logic [NC*AW-1:0]  fetch_addr_i;
  logic [NC-1:0]     fetch_rd_i;
  logic [NC*IW-1:0]  fetch_data_o;
  logic [NC-1:0]     fetch_valid_o;
  logic [NC-1:0]     fetch_stall_o;

  always #5 clk = ~clk;

  nx_instr_store_mc #(
    .INSTR_WIDTH (IW),
    .MAX_INSTRS  (MI),
    .CORES       (NC)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .clear_i       (clear_i),
    .store_core_i  (store_core_i),
    .store_data_i  (store_data_i),
    .store_valid_i (store_valid_i),
    .populated_o   (populated_o),
    .overflow_o    (overflow_o),
    .bad_core_o    (bad_core_o),
    .fetch_addr_i  (fetch_addr_i),
    .fetch_rd_i    (fetch_rd_i),
    .fetch_data_o  (fetch_data_o),
    .fetch_valid_o (fetch_valid_o),
    .fetch_stall_o (fetch_stall_o)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    int            core;
    logic [IW-1:0] data;
  } rsp_t;

  rsp_t          sbq[$];
  int            m_pop[NC];
  logic [IW-1:0] m_ram[NC][MI];
  logic [NC-1:0] m_ovf;
  logic          m_bad;
  int            m_ptr;
  logic [IW-1:0] m_data[NC];
  int            low_cnt[NC];

  task automatic model_reset();
    for (int c = 0; c < NC; c++) begin
      m_pop[c]  = 0;
      m_data[c] = '0;
    end
    m_ovf = '0;
    m_bad = 1'b0;
    m_ptr = NC - 1;
    sbq.delete();
  endtask

  function automatic logic [NC*CNTW-1:0] pack_pop();
    logic [NC*CNTW-1:0] v;
    v = '0;
    for (int c = 0; c < NC; c++) v[c*CNTW +: CNTW] = CNTW'(m_pop[c]);
    return v;
  endfunction

  task automatic check_outputs();
    logic [NC-1:0]    ev;
    logic [NC*IW-1:0] ed;
    rsp_t             r;
    ev = '0;
    if (sbq.size() > 0) ev[sbq[0].core] = 1'b1;
    chk("fetch_valid", fetch_valid_o, ev);
    if (sbq.size() > 0) begin
      r = sbq.pop_front();
      m_data[r.core] = r.data;
    end
    ed = '0;
    for (int c = 0; c < NC; c++) ed[c*IW +: IW] = m_data[c];
    chk("fetch_data", fetch_data_o, ed);
    chk("populated", populated_o, pack_pop());
    chk("overflow", overflow_o, m_ovf);
    chk("bad_core", bad_core_o, m_bad);
  endtask

  task automatic set_addr(input int c, input int a);
    fetch_addr_i[c*AW +: AW] = AW'(a);
  endtask

  // One clock: drive at negedge, check stalls before the edge, check registered outputs after it.
  task automatic step(input bit clr, input bit sv, input int sc, input logic [IW-1:0] sd,
                      input logic [NC-1:0] rd);
    logic [NC-1:0] g;
    int            idx;
    int            a;
    rsp_t          r;
    @(negedge clk);
    clear_i       = clr;
    store_valid_i = sv;
    store_core_i  = sc[CW-1:0];
    store_data_i  = sd;
    fetch_rd_i    = rd;
    g = '0;
    if (!sv) begin
      for (int i = 1; i <= NC; i++) begin
        idx = (m_ptr + i) % NC;
        if (g == '0 && rd[idx]) g[idx] = 1'b1;
      end
    end
    #1;
    chk("stall", fetch_stall_o, rd & ~g);
    for (int c = 0; c < NC; c++) if (!fetch_stall_o[c]) low_cnt[c]++;
    for (int c = 0; c < NC; c++) begin
      if (g[c]) begin
        a      = int'(fetch_addr_i[c*AW +: AW]);
        r.core = c;
        r.data = (a >= m_pop[c]) ? '0 : m_ram[c][a];
        sbq.push_back(r);
        m_ptr = c;
      end
    end
    if (clr) begin
      for (int c = 0; c < NC; c++) m_pop[c] = 0;
      m_ovf = '0;
    end else if (sv) begin
      if (sc >= NC) m_bad = 1'b1;
      else if (m_pop[sc] == MI) m_ovf[sc] = 1'b1;
      else begin
        m_ram[sc][m_pop[sc]] = sd;
        m_pop[sc]++;
      end
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  initial begin
    rst_i         = 1'b0;
    clear_i       = 1'b0;
    store_core_i  = '0;
    store_data_i  = '0;
    store_valid_i = 1'b0;
    fetch_addr_i  = '0;
    fetch_rd_i    = '0;
    model_reset();
    for (int c = 0; c < NC; c++) low_cnt[c] = 0;
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    chk("rst_stall", fetch_stall_o, 0);
    @(negedge clk);
    rst_i = 1'b1;

    // Three words to core 0, two to core 1, then fetch core 0 addr 2.
    step(0, 1, 0, 15'h101, 3'b000);
    step(0, 1, 0, 15'h102, 3'b000);
    step(0, 1, 0, 15'h103, 3'b000);
    step(0, 1, 1, 15'h201, 3'b000);
    step(0, 1, 1, 15'h202, 3'b000);
    chk("pop_3_2", populated_o, {4'd0, 4'd2, 4'd3});
    set_addr(0, 2);
    step(0, 0, 0, '0, 3'b001);
    chk("fetch0_addr2", fetch_data_o[IW-1:0], 15'h103);
    set_addr(0, 5);
    step(0, 0, 0, '0, 3'b001);
    chk("oob_zero", fetch_data_o[IW-1:0], 0);

    // Continuous contention from all cores.
    set_addr(0, 0);
    set_addr(1, 1);
    set_addr(2, 0);
    for (int c = 0; c < NC; c++) low_cnt[c] = 0;
    repeat (6) step(0, 0, 0, '0, 3'b111);
    chk("rr_core0", low_cnt[0], 2);
    chk("rr_core1", low_cnt[1], 2);
    chk("rr_core2", low_cnt[2], 2);

    // Load during contention blocks every grant; order resumes after.
    step(0, 1, 2, 15'h301, 3'b111);
    chk("load_stall_all", fetch_stall_o, 3'b111);
    repeat (3) step(0, 0, 0, '0, 3'b111);

    // Write then fetch of the just-written address next cycle.
    step(0, 1, 2, 15'h302, 3'b000);
    set_addr(2, 1);
    step(0, 0, 0, '0, 3'b100);
    chk("raw_core2", fetch_data_o[2*IW +: IW], 15'h302);

    // Nine loads to core 1 after a clear; ninth is dropped.
    step(1, 0, 0, '0, 3'b000);
    for (int i = 0; i < 9; i++) step(0, 1, 1, IW'(16'h400 + i), 3'b000);
    chk("ovf_flag", overflow_o, 3'b010);
    chk("ovf_pop1", populated_o[CNTW +: CNTW], 8);
    set_addr(1, 7);
    step(0, 0, 0, '0, 3'b010);
    chk("entry7_kept", fetch_data_o[IW +: IW], 15'h407);

    // Clear with a simultaneous load: clear wins, no flags.
    step(1, 1, 0, 15'h555, 3'b000);
    chk("clr_pop", populated_o, 0);
    chk("clr_ovf", overflow_o, 0);
    set_addr(0, 0);
    step(0, 0, 0, '0, 3'b001);
    chk("clr_fetch", fetch_data_o[IW-1:0], 0);

    // Load to a nonexistent core.
    step(0, 1, 3, 15'h666, 3'b000);
    chk("bad_flag", bad_core_o, 1);
    chk("bad_pop", populated_o, 0);

    // Reset while a response is being presented.
    step(0, 1, 0, 15'h777, 3'b000);
    set_addr(0, 0);
    step(0, 0, 0, '0, 3'b001);
    chk("pre_rst_data", fetch_data_o[IW-1:0], 15'h777);
    rst_i = 1'b0;
    #1;
    chk("rst_valid", fetch_valid_o, 0);
    chk("rst_data", fetch_data_o, 0);
    chk("rst_pop", populated_o, 0);
    chk("rst_bad", bad_core_o, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
